// File: rtl/jtframe_lfbuf_pkg.sv
// Shared types and constants for the line frame buffer PSRAM path.
package jtframe_lfbuf_pkg;

    localparam int unsigned AW = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        V_RUN = 2'd1,
        A_RUN = 2'd2
    } arb_st_t;

    localparam logic [1:0] OWN_IDLE = 2'd0;
    localparam logic [1:0] OWN_V    = 2'd1;
    localparam logic [1:0] OWN_A    = 2'd2;

endpackage

// File: rtl/jtframe_lfbuf_linetime.sv
// Line timing: lhbl falling-edge strobe, horizontal position and measured line period.
module jtframe_lfbuf_linetime (
    input  logic        rst,
    input  logic        clk,
    input  logic        lhbl,
    output logic        lfall_c,
    output logic [15:0] hpos,
    output logic [15:0] lp,
    output logic        lp_ok
);

    logic lhbl_l;
    logic seen;

    assign lfall_c = lhbl_l & ~lhbl;

    // Position counter restarts at each blanking start; the period is valid once a full line was seen
    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            lhbl_l <= 1'b0;
            seen   <= 1'b0;
            hpos   <= 16'd0;
            lp     <= 16'd0;
            lp_ok  <= 1'b0;
        end else begin
            lhbl_l <= lhbl;
            if (lfall_c) begin
                hpos <= 16'd0;
                lp   <= hpos;
                seen <= 1'b1;
                if (seen) lp_ok <= 1'b1;
            end else if (hpos != 16'hFFFF) begin
                hpos <= hpos + 16'd1;
            end
        end
    end

endmodule

// File: rtl/jtframe_lfbuf_arb.sv
// Arbitrates the PSRAM burst engine between the video line path and the aux port.
module jtframe_lfbuf_arb
    import jtframe_lfbuf_pkg::*;
#(
    parameter int unsigned LW     = 10,
    parameter int unsigned OVH    = 12,
    parameter int unsigned MARGIN = 16,
    parameter int unsigned STARVE = 4,
    parameter int unsigned TOUT   = 4095
)(
    input  logic          rst,
    input  logic          clk,
    input  logic          lhbl,
    input  logic          v_req,
    input  logic          v_we,
    input  logic [AW-1:0] v_addr,
    input  logic [LW-1:0] v_len,
    output logic          v_gnt,
    output logic          v_done,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [LW-1:0] a_len,
    output logic          a_gnt,
    output logic          a_done,
    output logic          eng_start,
    output logic          eng_we,
    output logic [AW-1:0] eng_addr,
    output logic [LW-1:0] eng_len,
    input  logic          eng_done,
    output logic [1:0]    owner,
    output logic          a_starve,
    output logic          err_tout
);

    localparam int unsigned TW = 12;
    localparam int unsigned SW = $clog2(STARVE + 1);

    arb_st_t       st;
    logic [TW-1:0] wdog;
    logic [SW-1:0] starve_cnt;
    logic          lfall_c;
    logic [15:0]   hpos;
    logic [15:0]   lp;
    logic          lp_ok;
    logic [16:0]   cost_c;
    logic          fits_c;

    jtframe_lfbuf_linetime u_linetime (
        .rst     ( rst     ),
        .clk     ( clk     ),
        .lhbl    ( lhbl    ),
        .lfall_c ( lfall_c ),
        .hpos    ( hpos    ),
        .lp      ( lp      ),
        .lp_ok   ( lp_ok   )
    );

    // An aux burst is allowed only if it ends, with margin, before the next blanking start
    assign cost_c = 17'(a_len) + 17'(OVH);
    assign fits_c = lp_ok && ((18'(hpos) + 18'(cost_c) + 18'(MARGIN)) < 18'(lp));

    assign a_starve = (starve_cnt == SW'(STARVE));

    assign owner = (st == V_RUN) ? OWN_V :
                   (st == A_RUN) ? OWN_A : OWN_IDLE;

    // Count lines on which a pending aux request was refused
    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (a_gnt) begin
            starve_cnt <= '0;
        end else if (lfall_c) begin
            if (!a_req)
                starve_cnt <= '0;
            else if (st != A_RUN && !a_starve)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Grant/complete state machine with engine watchdog
    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            wdog      <= '0;
            v_gnt     <= 1'b0;
            v_done    <= 1'b0;
            a_gnt     <= 1'b0;
            a_done    <= 1'b0;
            eng_start <= 1'b0;
            eng_we    <= 1'b0;
            eng_addr  <= '0;
            eng_len   <= '0;
            err_tout  <= 1'b0;
        end else begin
            v_gnt     <= 1'b0;
            v_done    <= 1'b0;
            a_gnt     <= 1'b0;
            a_done    <= 1'b0;
            eng_start <= 1'b0;
            case (st)
                IDLE: begin
                    wdog <= '0;
                    if (v_req) begin
                        eng_we    <= v_we;
                        eng_addr  <= v_addr;
                        eng_len   <= v_len;
                        eng_start <= 1'b1;
                        v_gnt     <= 1'b1;
                        st        <= V_RUN;
                    end else if (a_req && (fits_c || a_starve)) begin
                        eng_we    <= a_we;
                        eng_addr  <= a_addr;
                        eng_len   <= a_len;
                        eng_start <= 1'b1;
                        a_gnt     <= 1'b1;
                        st        <= A_RUN;
                    end
                end
                V_RUN, A_RUN: begin
                    if (eng_done || wdog == TW'(TOUT)) begin
                        if (!eng_done) err_tout <= 1'b1;
                        v_done <= (st == V_RUN);
                        a_done <= (st == A_RUN);
                        wdog   <= '0;
                        st     <= IDLE;
                    end else begin
                        wdog <= wdog + TW'(1);
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
